tx_gate_arbiter: RTL
====================

// Module: tx_gate_arbiter
// PURPOSE
// Shares one downstream TX engine between C_NUM_CHNL tx channel gates. Reads each gate's FIFO read
// side in the engine clock domain. Grants one channel per transaction in round-robin order.
// Forwards that transaction's header, then its data words, until the close marker arrives.
// Sits between the per-channel gates and the TX request/formatting engine.
// PARAMETERS
// C_NUM_CHNL        4                 number of gates, 1..12
// C_DATA_WIDTH      64                channel data width
// C_FIFO_DATA_WIDTH C_DATA_WIDTH+1    gate FIFO word; MSB=marker flag (derived, do not override)
// C_CHNL_W          $clog2(C_NUM_CHNL) (min 1)  channel index width (derived)
// PORTS
// CLK            in   1                          engine clock (gate FIFO RD_CLK)
// RST_N          in   1                          asynchronous, active-low reset
// GATE_RD_DATA   in   C_NUM_CHNL*C_FIFO_DATA_WIDTH  gate i FIFO head at slice i (first-word-fall-through)
// GATE_RD_EMPTY  in   C_NUM_CHNL                 gate i FIFO empty
// GATE_RD_EN     out  C_NUM_CHNL                 pop gate i FIFO head
// HDR_VALID      out  1                          header available
// HDR_READY      in   1                          engine accepts header
// HDR_CHNL       out  C_CHNL_W                   granted channel
// HDR_LEN        out  32                         transfer length (32-bit words)
// HDR_OFF        out  31                         transfer offset
// HDR_LAST       out  1                          last flag
// DATA           out  C_DATA_WIDTH               data word from granted gate
// DATA_VALID     out  1                          DATA valid
// DATA_READY     in   1                          engine accepts DATA
// DONE           out  1                          one-cycle pulse, transaction closed
// DONE_CHNL      out  C_CHNL_W                   channel that closed
// DONE_WORDS     out  32                         data words forwarded, saturates at 32'hFFFF_FFFF
// ERR            out  C_NUM_CHNL                 sticky per-channel protocol error
// BEHAVIOUR
// - Word decode: marker=w[C_DATA_WIDTH]. A header has a marker and a non-zero payload
//   {len[31:0],off[30:0],last}. A close has a marker and a zero payload. A data word has no marker.
// - Reset (async assert, sync deassert by the caller): state=SCAN, rPtr=0. All outputs 0; ERR=0.
// - SCAN: pick the first non-empty gate at or after rPtr, wrapping; this is combinational.
//   At most one pop per cycle:
//   header -> pop; register fields and grant into HDR_*; HDR_VALID=1 on the next cycle; go to HDR.
//   close (the duplicate end marker, or a zero-length non-last open) -> pop, discard, stay in SCAN; rPtr unchanged.
//   data word -> pop, discard, set ERR[i], stay in SCAN.
//   All gates empty -> idle; no pop.
// - HDR: HDR_* held stable while HDR_VALID=1. When HDR_VALID&HDR_READY, go to DATA and clear the word counter.
// - DATA: DATA is driven combinationally from the granted gate.
//   DATA_VALID = !empty[g] & !marker. GATE_RD_EN[g] = DATA_VALID & DATA_READY.
//   Each accepted word increments the counter (saturating).
//   Close at head -> pop it; go to DONE. A header at head (missing close) -> do not pop; set ERR[g]; go to DONE.
// - DONE: DONE=1 for exactly one cycle, with DONE_CHNL=g and DONE_WORDS=count.
//   rPtr = (g==C_NUM_CHNL-1) ? 0 : g+1; return to SCAN.
// - Latency: header at FIFO head -> HDR_VALID after 1 cycle. Data is zero-latency pass-through.
//   Close -> DONE after 1 cycle. Minimum back-to-back transaction gap is 2 cycles (DONE, SCAN).
// - GATE_RD_EN is never asserted for an empty gate, and never for more than one gate at a time.
// - Ungranted gates are never popped outside SCAN. A gate may not start a second transaction while
//   its first is open.
// - C_NUM_CHNL=1: rPtr is always 0; behaviour is otherwise identical.
// - Reset mid-transaction aborts without DONE. The gates share the reset and flush their FIFOs.
// STRUCTURE
// - Package tx_gate_arb_pkg: state enum {S_SCAN,S_HDR,S_DATA,S_DONE}; header field positions
//   (LEN_MSB/LSB, OFF_MSB/LSB, LAST_BIT); marker bit index helper.
// - Sub-module rr_pick #(N): request vector + start pointer -> one-hot grant + index + any.
//   Purely combinational; reused by other arbiters.
// - Top: FSM, header registers, word counter, data/empty mux, GATE_RD_EN decode, ERR register.
// TESTING
// 1 Gate1: header len=8 off=0 last=1; 4 data words; 2 closes -> HDR_CHNL=1 LEN=8 LAST=1;
//   4 DATA beats; DONE with WORDS=4; 2nd close silently dropped in SCAN.
// 2 Gates 0,2,3 all hold headers, rPtr=0 -> grants in order 0,2,3; after gate3 DONE, rPtr=0.
//   Gate0 reposted -> grant 0.
// 3 DATA_READY toggles 1/0 every cycle during 6-word transfer -> no word lost or duplicated;
//   GATE_RD_EN only on accepted beats; DONE_WORDS=6.
// 4 HDR_READY held low 10 cycles -> HDR_* stable; no gate popped; then proceeds normally.
// 5 Data word at gate2 head while in SCAN -> popped, ERR[2]=1 and sticky; other channels unaffected.
// 6 Assert RST_N low mid-DATA (3 of 5 words sent) -> outputs 0 immediately, no DONE;
//   after release the next header is granted from rPtr=0.

Source files
------------

// File: rtl/tx_gate_arb_pkg.sv
// Shared types and header field layout for the TX gate arbiter.
// Header payload is {len[31:0], off[30:0], last} in the low 64 bits of a marked word.
package tx_gate_arb_pkg;

  typedef enum logic [1:0] {
    S_SCAN = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int HDR_PL_W = 64;
  localparam int LEN_MSB  = 63;
  localparam int LEN_LSB  = 32;
  localparam int OFF_MSB  = 31;
  localparam int OFF_LSB  = 1;
  localparam int LAST_BIT = 0;

  // The marker flag sits just above the data payload in each FIFO word.
  function automatic int marker_bit(input int data_width);
    return data_width;
  endfunction

  function automatic int chnl_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping.
// Purely combinational; grant is one-hot, idx_o is its index, any_o flags a hit.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = W'(j);
      end
    end
  end

endmodule

// File: rtl/tx_gate_arbiter.sv
// Shares one TX engine between C_NUM_CHNL gate FIFOs: grants one channel per
// transaction round-robin, forwards its header, then streams data until the close marker.
module tx_gate_arbiter
  import tx_gate_arb_pkg::*;
#(
  parameter int C_NUM_CHNL   = 4,
  parameter int C_DATA_WIDTH = 64
) (
  input  logic                                     CLK,
  input  logic                                     RST_N,
  input  logic [C_NUM_CHNL*(C_DATA_WIDTH+1)-1:0]   GATE_RD_DATA,
  input  logic [C_NUM_CHNL-1:0]                    GATE_RD_EMPTY,
  output logic [C_NUM_CHNL-1:0]                    GATE_RD_EN,
  output logic                                     HDR_VALID,
  input  logic                                     HDR_READY,
  output logic [chnl_w(C_NUM_CHNL)-1:0]            HDR_CHNL,
  output logic [31:0]                              HDR_LEN,
  output logic [30:0]                              HDR_OFF,
  output logic                                     HDR_LAST,
  output logic [C_DATA_WIDTH-1:0]                  DATA,
  output logic                                     DATA_VALID,
  input  logic                                     DATA_READY,
  output logic                                     DONE,
  output logic [chnl_w(C_NUM_CHNL)-1:0]            DONE_CHNL,
  output logic [31:0]                              DONE_WORDS,
  output logic [C_NUM_CHNL-1:0]                    ERR
);

  localparam int FW = C_DATA_WIDTH + 1;
  localparam int CW = chnl_w(C_NUM_CHNL);
  localparam int MK = marker_bit(C_DATA_WIDTH);

  // Handshakes: a transfer happens on a cycle where VALID and READY are both high;
  // VALID never depends on READY, and the offered HDR_* / DATA stay put until taken.

  state_e                state_q, state_d;
  logic [CW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         gnt_q, gnt_d;
  logic [31:0]           len_q, len_d;
  logic [30:0]           off_q, off_d;
  logic                  last_q, last_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [C_NUM_CHNL-1:0] err_q, err_d;

  logic [FW-1:0]         head_w [C_NUM_CHNL];
  logic [C_NUM_CHNL-1:0] pick_gnt;
  logic [CW-1:0]         pick_idx;
  logic                  pick_any;
  logic [FW-1:0]         scan_w, sel_w;
  logic [HDR_PL_W-1:0]   scan_pl;
  logic                  sel_empty;

  for (genvar i = 0; i < C_NUM_CHNL; i++) begin : g_slice
    assign head_w[i] = GATE_RD_DATA[i*FW +: FW];
  end

  rr_pick #(.N(C_NUM_CHNL), .W(CW)) u_pick (
    .req_i (~GATE_RD_EMPTY),
    .ptr_i (rptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign scan_w    = head_w[pick_idx];
  assign sel_w     = head_w[gnt_q];
  assign sel_empty = GATE_RD_EMPTY[gnt_q];
  assign scan_pl   = HDR_PL_W'(scan_w[C_DATA_WIDTH-1:0]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_SCAN;
      rptr_q  <= '0;
      gnt_q   <= '0;
      len_q   <= '0;
      off_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      off_q   <= off_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    gnt_d      = gnt_q;
    len_d      = len_q;
    off_d      = off_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    GATE_RD_EN = '0;
    DATA       = '0;
    DATA_VALID = 1'b0;

    unique case (state_q)
      S_SCAN: begin
        if (pick_any) begin
          GATE_RD_EN = pick_gnt;
          if (!scan_w[MK]) begin
            err_d[pick_idx] = 1'b1;
          end else if (|scan_w[C_DATA_WIDTH-1:0]) begin
            gnt_d   = pick_idx;
            len_d   = scan_pl[LEN_MSB:LEN_LSB];
            off_d   = scan_pl[OFF_MSB:OFF_LSB];
            last_d  = scan_pl[LAST_BIT];
            state_d = S_HDR;
          end
        end
      end

      S_HDR: begin
        if (HDR_READY) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        DATA = sel_w[C_DATA_WIDTH-1:0];
        if (!sel_empty) begin
          if (!sel_w[MK]) begin
            DATA_VALID = 1'b1;
            if (DATA_READY) begin
              GATE_RD_EN[gnt_q] = 1'b1;
              if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
            end
          end else begin
            // A header here means the close went missing: leave it for the next scan.
            if (|sel_w[C_DATA_WIDTH-1:0]) err_d[gnt_q] = 1'b1;
            else                          GATE_RD_EN[gnt_q] = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        rptr_d  = (gnt_q == CW'(C_NUM_CHNL - 1)) ? '0 : gnt_q + CW'(1);
        state_d = S_SCAN;
      end

      default: state_d = S_SCAN;
    endcase
  end

  assign HDR_VALID  = (state_q == S_HDR);
  assign HDR_CHNL   = gnt_q;
  assign HDR_LEN    = len_q;
  assign HDR_OFF    = off_q;
  assign HDR_LAST   = last_q;
  assign DONE       = (state_q == S_DONE);
  assign DONE_CHNL  = DONE ? gnt_q : '0;
  assign DONE_WORDS = DONE ? cnt_q : '0;
  assign ERR        = err_q;

endmodule
